// File: rtl/gsim_pkg.sv
// Shared definitions for the banded Gauss-Seidel solver:
// stencil coefficients, controller state encoding and a signed saturation helper.
package gsim_pkg;

  // Row stencil: 20*x_i - 13*x_{i+-1} + 6*x_{i+-2} - x_{i+-3}
  localparam int unsigned COEF_C0 = 20;
  localparam int unsigned COEF_C1 = 13;
  localparam int unsigned COEF_C2 = 6;
  localparam int unsigned COEF_C3 = 1;

  // Working width of the saturation helper; callers must fit within it.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    ST_RECV = 2'd0,
    ST_CALC = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Clamp v to the signed range of a w-bit value (w <= SAT_W).
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    lo = -hi - $signed(SAT_W'(1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/gsim_div20.sv
// Exact signed floor division of the (X_W+8)-bit stencil numerator by 20,
// saturated to the signed X_W range. Purely combinational.
// Ports: num_i - numerator S; quo_o - floor(S/20) clamped to X_W bits.
module gsim_div20
  import gsim_pkg::*;
#(
  parameter int unsigned X_W = 32
) (
  input  logic signed [X_W+7:0] num_i,
  output logic signed [X_W-1:0] quo_o
);

  localparam int unsigned SW = X_W + 8;
  localparam logic signed [SW-1:0] DIV = SW'(COEF_C0);
  localparam logic signed [SW-1:0] ONE = SW'(1);

  logic signed [SW-1:0]    q_trunc;
  logic signed [SW-1:0]    r_trunc;
  logic signed [SW-1:0]    q_floor;
  logic signed [SAT_W-1:0] q_sat;

  // Native division truncates toward zero; step down once for negative inexact results.
  always_comb begin
    q_trunc = num_i / DIV;
    r_trunc = num_i % DIV;
    q_floor = (num_i[SW-1] && (r_trunc != '0)) ? (q_trunc - ONE) : q_trunc;
    q_sat   = sat_signed(SAT_W'(q_floor), X_W);
    quo_o   = X_W'(q_sat);
  end

endmodule

// File: rtl/gsim_solver_param.sv
// N-unknown banded Gauss-Seidel solver. Collects b over a valid/ready stream,
// runs in-place sweeps (one unknown per cycle) until the per-sweep max change
// is within tol or iter_max sweeps are done, then streams x out with backpressure.
// Ports: clk/reset (async, active-high); in_valid/in_ready/b_in with iter_max and
// tol sampled on b[0]; out_valid/out_ready/x_out/out_last with converged and
// iter_used valid alongside out_valid.
module gsim_solver_param
  import gsim_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned B_W  = 16,
  parameter int unsigned X_W  = 32,
  parameter int unsigned FRAC = 16,
  parameter int unsigned IT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [B_W-1:0]  b_in,
  input  logic        [IT_W-1:0] iter_max,
  input  logic        [X_W-1:0]  tol,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [X_W-1:0]  x_out,
  output logic                   out_last,
  output logic                   converged,
  output logic        [IT_W-1:0] iter_used
);

  localparam int unsigned SW    = X_W + 8;
  localparam int unsigned DW    = X_W + 1;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [SW-1:0] K1 = SW'(COEF_C1);
  localparam logic signed [SW-1:0] K2 = SW'(COEF_C2);
  localparam logic signed [SW-1:0] K3 = SW'(COEF_C3);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q, k_q, oidx_q;
  logic [IT_W-1:0]         sweeps_q, iter_max_q;
  logic [X_W-1:0]          tol_q;
  logic [DW-1:0]           maxdelta_q;
  logic signed [B_W-1:0]   b_q [N];
  logic signed [X_W-1:0]   x_q [N];

  logic                    in_ready_q, out_valid_q, out_last_q, converged_q;
  logic signed [X_W-1:0]   x_out_q;
  logic [IT_W-1:0]         iter_used_q;

  int                      kpos;
  logic signed [SW-1:0]    num_d;
  logic signed [X_W-1:0]   x_new_d;
  logic signed [DW-1:0]    diff_d;
  logic [DW-1:0]           absd_d, maxdelta_d;
  logic [IT_W-1:0]         sweeps_d;
  logic                    conv_d;
  logic [IDX_W-1:0]        oidx_nxt_d;

  // Neighbour fetch; indices outside 0..N-1 contribute zero.
  function automatic logic signed [SW-1:0] x_at(input int pos);
    if ((pos < 0) || (pos >= int'(N))) return '0;
    return SW'(x_q[IDX_W'(pos)]);
  endfunction

  // Stencil numerator, change tracking and end-of-sweep decision for unknown k.
  always_comb begin
    kpos       = int'(k_q);
    num_d      = (SW'(b_q[k_q]) <<< FRAC)
               + K1 * (x_at(kpos - 1) + x_at(kpos + 1))
               - K2 * (x_at(kpos - 2) + x_at(kpos + 2))
               + K3 * (x_at(kpos - 3) + x_at(kpos + 3));
    diff_d     = DW'(x_new_d) - DW'(x_q[k_q]);
    absd_d     = diff_d[DW-1] ? $unsigned(-diff_d) : $unsigned(diff_d);
    maxdelta_d = (absd_d > maxdelta_q) ? absd_d : maxdelta_q;
    sweeps_d   = sweeps_q + IT_W'(1);
    conv_d     = (maxdelta_d <= {1'b0, tol_q});
    oidx_nxt_d = oidx_q + IDX_W'(1);
  end

  gsim_div20 #(.X_W(X_W)) u_div20 (
    .num_i (num_d),
    .quo_o (x_new_d)
  );

  // Controller, storage and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RECV;
      idx_q       <= '0;
      k_q         <= '0;
      oidx_q      <= '0;
      sweeps_q    <= '0;
      iter_max_q  <= '0;
      tol_q       <= '0;
      maxdelta_q  <= '0;
      b_q         <= '{default: '0};
      x_q         <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      out_last_q  <= 1'b0;
      converged_q <= 1'b0;
      iter_used_q <= '0;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (in_valid && in_ready_q) begin
            b_q[idx_q] <= b_in;
            if (idx_q == '0) begin
              iter_max_q <= iter_max;
              tol_q      <= tol;
              x_q        <= '{default: '0};
            end
            if (idx_q == LAST_IDX) begin
              idx_q      <= '0;
              k_q        <= '0;
              sweeps_q   <= '0;
              maxdelta_q <= '0;
              in_ready_q <= 1'b0;
              if (iter_max_q == '0) begin
                // Zero sweep budget: report the cleared x immediately.
                state_q     <= ST_SEND;
                oidx_q      <= '0;
                out_valid_q <= 1'b1;
                x_out_q     <= '0;
                out_last_q  <= 1'b0;
                converged_q <= 1'b0;
                iter_used_q <= '0;
              end else begin
                state_q <= ST_CALC;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end

        ST_CALC: begin
          x_q[k_q] <= x_new_d;
          if (k_q == LAST_IDX) begin
            sweeps_q <= sweeps_d;
            if (conv_d || (sweeps_d == iter_max_q)) begin
              state_q     <= ST_SEND;
              oidx_q      <= '0;
              out_valid_q <= 1'b1;
              x_out_q     <= x_q[0];
              out_last_q  <= 1'b0;
              converged_q <= conv_d;
              iter_used_q <= sweeps_d;
            end else begin
              k_q        <= '0;
              maxdelta_q <= '0;
            end
          end else begin
            k_q        <= k_q + IDX_W'(1);
            maxdelta_q <= maxdelta_d;
          end
        end

        ST_SEND: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= ST_RECV;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              idx_q       <= '0;
            end else begin
              oidx_q     <= oidx_nxt_d;
              x_out_q    <= x_q[oidx_nxt_d];
              out_last_q <= (oidx_nxt_d == LAST_IDX);
            end
          end
        end

        default: begin
          state_q    <= ST_RECV;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign out_last  = out_last_q;
  assign converged = converged_q;
  assign iter_used = iter_used_q;

endmodule

// File: tb/tb_gsim_solver_param.sv
// Bench for gsim_solver_param: table of N=16 jobs checked against hand values
// and a floor-divide reference model, plus reset-abort and N=8 sequences.
module tb_gsim_solver_param;

  localparam int unsigned B_W  = 16;
  localparam int unsigned X_W  = 32;
  localparam int unsigned IT_W = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic                   in_valid, in_ready, out_valid, out_ready, out_last, converged;
  logic signed [B_W-1:0]  b_in;
  logic [IT_W-1:0]        iter_max, iter_used;
  logic [X_W-1:0]         tol;
  logic signed [X_W-1:0]  x_out;

  logic                   in_valid8, in_ready8, out_valid8, out_ready8, out_last8, converged8;
  logic signed [B_W-1:0]  b_in8;
  logic [IT_W-1:0]        iter_max8, iter_used8;
  logic [X_W-1:0]         tol8;
  logic signed [X_W-1:0]  x_out8;

  gsim_solver_param #(.N(16), .B_W(B_W), .X_W(X_W), .FRAC(16), .IT_W(IT_W)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .b_in(b_in),
    .iter_max(iter_max), .tol(tol), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .out_last(out_last), .converged(converged), .iter_used(iter_used));

  gsim_solver_param #(.N(8), .B_W(B_W), .X_W(X_W), .FRAC(16), .IT_W(IT_W)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8), .b_in(b_in8),
    .iter_max(iter_max8), .tol(tol8), .out_valid(out_valid8), .out_ready(out_ready8),
    .x_out(x_out8), .out_last(out_last8), .converged(converged8), .iter_used(iter_used8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference model state
  longint mb [16];
  longint mx [16];
  int     m_used;
  bit     m_conv;
  longint hx [3] = '{64'h10000, 64'hA666, 64'h1F5B};

  function automatic longint g(input int n, input int p);
    if (p < 0 || p >= n) return 0;
    return mx[p];
  endfunction

  task automatic model(input int n, input int itmax, input longint tolv);
    longint s, q, d, md;
    for (int i = 0; i < 16; i++) mx[i] = 0;
    m_used = 0;
    m_conv = 0;
    if (itmax == 0) return;
    while (1) begin
      md = 0;
      for (int k = 0; k < n; k++) begin
        s = mb[k] * 65536 + 13 * (g(n, k-1) + g(n, k+1)) - 6 * (g(n, k-2) + g(n, k+2))
            + g(n, k-3) + g(n, k+3);
        q = s / 20;
        if ((s % 20) != 0 && s < 0) q = q - 1;
        if (q > 64'sh7FFFFFFF) q = 64'sh7FFFFFFF;
        if (q < -64'sh80000000) q = -64'sh80000000;
        d = q - mx[k];
        if (d < 0) d = -d;
        if (d > md) md = d;
        mx[k] = q;
      end
      m_used++;
      if (md <= tolv) begin m_conv = 1; break; end
      if (m_used == itmax) break;
    end
  endtask

  task automatic setup_b(input int n, input int b0, input int fill);
    for (int i = 0; i < 16; i++) mb[i] = 0;
    mb[0] = b0;
    for (int i = 1; i < n; i++)
      mb[i] = (fill == 1) ? longint'((i * 3719) % 2001 - 1000) : (fill == 2) ? longint'(b0) : 0;
  endtask

  typedef struct {
    string  name;
    int     b0;
    int     fill;
    int     itmax;
    longint tolv;
    bit     bp;
    int     exp_used;   // -1: take from model
    int     exp_conv;   // -1: take from model
    bit     hand_x;
  } vec_t;

  vec_t vt [6];

  task automatic send16(input int itmax, input longint tolv, output int e0);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      b_in     = B_W'(mb[i]);
      if (i == 0) begin
        iter_max = IT_W'(itmax);
        tol      = X_W'(tolv);
      end else begin
        iter_max = '1;
        tol      = X_W'($urandom);
      end
      if (i == 0 || i == 15) chk($sformatf("in_ready_recv[%0d]", i), 64'(in_ready), 1);
      @(posedge clk); #1;
    end
    e0 = cyc;
    // Junk while busy; must be ignored
    b_in     = 16'sh7FFF;
    iter_max = '1;
  endtask

  task automatic wait16(input string nm, input int e0, input int exp_lat, output bit ok);
    int guard = 0;
    while (!out_valid && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    ok = out_valid;
    if (!ok) begin
      chk({nm, ".timeout"}, 0, 1);
      return;
    end
    chk({nm, ".latency"}, 64'(cyc - e0 + 1), 64'(exp_lat));
  endtask

  task automatic run16(input vec_t v);
    int e0, eu, ec;
    bit ok;
    setup_b(16, v.b0, v.fill);
    model(16, v.itmax, v.tolv);
    eu = (v.exp_used >= 0) ? v.exp_used : m_used;
    ec = (v.exp_conv >= 0) ? v.exp_conv : int'(m_conv);
    send16(v.itmax, v.tolv, e0);
    wait16(v.name, e0, eu * 16 + 1, ok);
    if (!ok) return;
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      if (v.bp && j == 3) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk($sformatf("%s.stall%0d.valid", v.name, s), 64'(out_valid), 1);
          chk($sformatf("%s.stall%0d.x", v.name, s), x_out, mx[3]);
          chk($sformatf("%s.stall%0d.last", v.name, s), 64'(out_last), 0);
          chk($sformatf("%s.stall%0d.in_ready", v.name, s), 64'(in_ready), 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      chk($sformatf("%s.valid[%0d]", v.name, j), 64'(out_valid), 1);
      chk($sformatf("%s.x[%0d]", v.name, j), x_out, mx[j]);
      chk($sformatf("%s.last[%0d]", v.name, j), 64'(out_last), (j == 15) ? 1 : 0);
      if (v.hand_x && j < 3) chk($sformatf("%s.hand_x[%0d]", v.name, j), x_out, hx[j]);
      if (j == 0 || j == 15) begin
        chk($sformatf("%s.converged[%0d]", v.name, j), 64'(converged), 64'(ec));
        chk($sformatf("%s.iter_used[%0d]", v.name, j), 64'(iter_used), 64'(eu));
      end
      @(posedge clk); #1;
    end
    chk({v.name, ".idle_valid"}, 64'(out_valid), 0);
    chk({v.name, ".idle_in_ready"}, 64'(in_ready), 1);
  endtask

  initial begin
    int e0, guard;
    bit ok;

    vt[0] = '{"t1_single_sweep", 20, 0, 1, 64'd0, 1'b0, 1, 0, 1'b1};
    vt[1] = '{"t2_itmax_zero", 5, 1, 0, 64'd0, 1'b0, 0, 0, 1'b0};
    vt[2] = '{"t3_tol_wide", 20, 0, 100, 64'h7FFFFFFF, 1'b0, 1, 1, 1'b0};
    vt[3] = '{"t4_backpressure", 20, 0, 3, 64'd0, 1'b1, -1, -1, 1'b0};
    vt[4] = '{"pattern_tol", 7, 1, 200, 64'h40, 1'b0, -1, -1, 1'b0};
    vt[5] = '{"neg_full_scale", -32768, 2, 30, 64'd0, 1'b0, -1, -1, 1'b0};

    in_valid = 1'b0; b_in = '0; iter_max = '0; tol = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; b_in8 = '0; iter_max8 = '0; tol8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 1);
    chk("rst.out_valid", 64'(out_valid), 0);
    chk("rst.x_out", x_out, 0);
    chk("rst.out_last", 64'(out_last), 0);
    chk("rst.converged", 64'(converged), 0);
    chk("rst.iter_used", 64'(iter_used), 0);
    chk("rst.in_ready8", 64'(in_ready8), 1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run16(vt[i]);

    // Abort during sweep 2 at k=7, then a clean job must match the model.
    setup_b(16, 3, 1);
    send16(100, 0, e0);
    in_valid = 1'b0;
    while (cyc < e0 + 23) begin @(posedge clk); #1; end
    chk("abort.pre_in_ready", 64'(in_ready), 0);
    reset = 1'b1;
    #1;
    chk("abort.in_ready", 64'(in_ready), 1);
    chk("abort.out_valid", 64'(out_valid), 0);
    @(posedge clk); #1;
    chk("abort.hold_in_ready", 64'(in_ready), 1);
    chk("abort.hold_out_valid", 64'(out_valid), 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run16(vt[4]);

    // N=8 instance with random b.
    for (int i = 0; i < 16; i++) mb[i] = 0;
    for (int i = 0; i < 8; i++) mb[i] = longint'($signed(16'($urandom)));
    model(8, 50, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid8 = 1'b1;
      b_in8     = B_W'(mb[i]);
      iter_max8 = (i == 0) ? IT_W'(50) : '1;
      tol8      = (i == 0) ? '0 : X_W'($urandom);
      @(posedge clk); #1;
    end
    e0 = cyc;
    in_valid8 = 1'b0;
    guard = 0;
    while (!out_valid8 && guard < 5000) begin @(posedge clk); #1; guard++; end
    ok = out_valid8;
    if (!ok) chk("n8.timeout", 0, 1);
    else begin
      chk("n8.latency", 64'(cyc - e0 + 1), 64'(m_used * 8 + 1));
      chk("n8.converged", 64'(converged8), 64'(m_conv));
      chk("n8.iter_used", 64'(iter_used8), 64'(m_used));
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("n8.x[%0d]", j), x_out8, mx[j]);
        chk($sformatf("n8.last[%0d]", j), 64'(out_last8), (j == 7) ? 1 : 0);
        @(posedge clk); #1;
      end
      chk("n8.idle_valid", 64'(out_valid8), 0);
      chk("n8.idle_in_ready", 64'(in_ready8), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
